uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  Parametrised UART transmit frame engine. Latches a parallel word and serialises it as
//  start / data (LSB first) / optional parity / 1 or 2 stop bits, with a registered line output.
//  Sits between the TX data source (register file / FIFO pop) and the TX pad.
//  Successor to the fixed 4-way TX output mux: the FSM, baud timing and parity are built in.
// PARAMETERS
//  DATA_WIDTH    8   data bits per frame, legal range 5..9
//  CLKS_PER_BIT  16  clk cycles each line bit is held, >=1; 1 = one bit per clk
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  rst         in   1           synchronous reset, active-high
//  data_valid  in   1           request to send p_data; sampled only while busy==0
//  p_data      in   DATA_WIDTH  word to transmit
//  par_en      in   1           1 = insert parity bit
//  par_typ     in   1           0 = even parity, 1 = odd parity
//  stop2       in   1           0 = one stop bit, 1 = two stop bits
//  tx_out      out  1           serial line, registered, idles high
//  busy        out  1           high while a frame is in progress
//  tx_done     out  1           one-cycle pulse at end of frame
// BEHAVIOUR
//  Reset: rst high at a posedge -> state IDLE, tx_out=1, busy=0, tx_done=0, counters=0.
//   Reset mid-frame aborts the frame; the line returns high on that edge.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE: tx_out=1. data_valid==1 at an edge -> accept: latch p_data, par_en, par_typ, stop2;
//     busy<=1; tx_out<=0; state<=START. Accept needs state IDLE, not just busy==0.
//   START: hold 0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   DATA: drive data_q[bit_idx] for CLKS_PER_BIT cycles each, idx 0..DATA_WIDTH-1.
//     Then go to PARITY if par_en_q, else go to STOP.
//   PARITY: drive ^data_q XOR par_typ_q for CLKS_PER_BIT cycles -> STOP.
//   STOP: drive 1 for CLKS_PER_BIT*(1+stop2_q) cycles -> IDLE.
//     busy<=0 and tx_done<=1 on that edge.
//  Timing: tx_out is registered; its value changes on the same edge as the state register.
//   The start bit appears on the edge that samples data_valid=1. Every bit lasts exactly
//   CLKS_PER_BIT cycles. Frame = (2+DATA_WIDTH+par_en+stop2)*CLKS_PER_BIT cycles.
//  Handshake: data_valid while busy==1 is ignored, not queued.
//   p_data and config changes during a frame have no effect.
//   Back-to-back: the edge after tx_done can accept, so at least 1 idle-high cycle between frames.
//  Counters: baud counter is max($clog2(CLKS_PER_BIT),1) bits and counts 0..CLKS_PER_BIT-1.
//   It wraps on each bit boundary. bit_idx is $clog2(DATA_WIDTH) bits with no wrap past
//   DATA_WIDTH-1. No glitches: tx_out is driven only from the flop.
//  tx_done is high for exactly 1 cycle per completed frame and never on an aborted frame.
// TESTING
//  1 Reset: rst=1 for 3 cycles with data_valid=1 -> tx_out=1, busy=0, tx_done=0 throughout.
//  2 Frame: DW=8, CPB=4, par_en=0, stop2=0, p_data=8'hA5.
//    Line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles); tx_done 1 cycle at the end.
//  3 Parity: p_data=8'hA5, par_en=1 -> parity bit 0 with par_typ=0, 1 with par_typ=1.
//    stop2=1 -> stop held 8 cycles; total 48 cycles.
//  4 Busy ignore: during frame, data_valid=1 with p_data=8'h3C.
//    The frame in flight is unchanged and no second frame starts.
//  5 Back-to-back: data_valid held high with CPB=1, 0xFF then 0x00.
//    Exactly 1 idle-high cycle between the two frames; 2 tx_done pulses.
//  6 Mid-frame reset: rst in DATA bit 3 -> next edge tx_out=1, busy=0, no tx_done.
//    A new accept after reset produces a correct frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// The serial line is driven straight from a flop that updates on the same edge as the FSM.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   baud_cnt, baud_nx;
  logic [IW-1:0]   bit_idx, idx_nx;
  logic            stop_cnt, stop_nx;
  logic            tx_nx, busy_nx, done_nx;
  logic            bit_end, accept;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q, stop2_q;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign accept  = (state == IDLE) && data_valid;

  // NOTE: sequential state uses <= only; the combinational block below uses = so later
  // statements can read values computed earlier in the same pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= idx_nx;
      stop_cnt <= stop_nx;
      tx_out   <= tx_nx;
      busy     <= busy_nx;
      tx_done  <= done_nx;
    end
  end

  // NOTE: the frame payload needs no reset; it is only observed after an accept has loaded it.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q    <= p_data;
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
      stop2_q   <= stop2;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    idx_nx   = bit_idx;
    stop_nx  = stop_cnt;
    tx_nx    = tx_out;
    busy_nx  = busy;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        if (data_valid) begin
          state_nx = START;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
          baud_nx  = '0;
          stop_nx  = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_nx = DATA;
          baud_nx  = '0;
          idx_nx   = '0;
          tx_nx    = data_q[0];
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_nx = '0;
          if (bit_idx == IDX_LAST) begin
            if (par_en_q) begin
              state_nx = PARITY;
              tx_nx    = (^data_q) ^ par_typ_q;
            end else begin
              state_nx = STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            idx_nx = bit_idx + 1'b1;
            tx_nx  = data_q[idx_nx];
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
          baud_nx  = '0;
          tx_nx    = 1'b1;
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_nx = '0;
          // Second stop bit reuses the baud counter; stop_cnt marks which half we are in.
          if (stop2_q && !stop_cnt) begin
            stop_nx = 1'b1;
          end else begin
            state_nx = IDLE;
            idx_nx   = '0;
            stop_nx  = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule
